frequency_meter: RTL and testbench

- Equal-precision (reciprocal) frequency meter.
- A 10 MHz reference clock clk_ref samples an asynchronous input clk_meas.
- The actual gate opens and closes on synchronized clk_meas rising edges, so each gate spans a whole number of clk_meas periods. Reference cycles and measured edges are counted inside the gate; f_meas = f_ref * meas_out / ref_out.
- Gate start/stop strobes are exported for an external TDC that resolves the sub-cycle edge-alignment error.

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/meas_edge_sync.sv | 34 +++
 rtl/frequency_meter.sv | 115 +++++++++++
 tb/tb_frequency_meter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default dimensions for the reciprocal frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        ARM  = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int unsigned DefGateCycles    = 100_000;
    localparam int unsigned DefTimeoutCycles = 400_000;
    localparam int unsigned DefCntW          = 32;

endpackage

// File: rtl/meas_edge_sync.sv
// Brings the asynchronous measured clock into the clk_ref domain and emits
// a one-cycle pulse per synchronized rising edge.
module meas_edge_sync (
    input  logic clk_ref,
    input  logic sys_rstn,
    input  logic meas_i,
    output logic edge_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    always_comb begin
        sync1_d = meas_i;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign edge_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/frequency_meter.sv
// Equal-precision frequency meter: gates open and close on measured edges,
// counting reference cycles and measured edges inside each gate.
module frequency_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = DefGateCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter int unsigned CNT_W          = DefCntW
) (
    input  logic             sys_rstn,
    input  logic             clk_ref,
    input  logic             clk_meas,
    output logic [CNT_W-1:0] ref_out,
    output logic [CNT_W-1:0] meas_out,
    output logic             start_pos_ext,
    output logic             start_neg_ext,
    output logic             stop_pos_ext,
    output logic             stop_neg_ext
);

    localparam logic [CNT_W-1:0] GateLim    = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYCLES);

    logic             meas_edge;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic [CNT_W-1:0] ref_out_q, ref_out_d;
    logic [CNT_W-1:0] meas_out_q, meas_out_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] ref_inc, meas_inc;

    meas_edge_sync u_sync (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .meas_i   (clk_meas),
        .edge_o   (meas_edge)
    );

    // Saturating increments; the closing cycle itself is included in the count.
    assign ref_inc  = (&ref_cnt_q)  ? ref_cnt_q  : ref_cnt_q + 1'b1;
    assign meas_inc = (&meas_cnt_q) ? meas_cnt_q : meas_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ref_cnt_d  = ref_cnt_q;
        meas_cnt_d = meas_cnt_q;
        ref_out_d  = ref_out_q;
        meas_out_d = meas_out_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        case (state_q)
            ARM: begin
                if (meas_edge) begin
                    start_d    = 1'b1;
                    ref_cnt_d  = '0;
                    meas_cnt_d = '0;
                    state_d    = MEAS;
                end
            end
            MEAS: begin
                if (meas_edge && (ref_inc >= GateLim)) begin
                    // Closing edge doubles as the next gate's opening edge.
                    ref_out_d  = ref_inc;
                    meas_out_d = meas_inc;
                    start_d    = 1'b1;
                    stop_d     = 1'b1;
                    ref_cnt_d  = '0;
                    meas_cnt_d = '0;
                end else if (ref_inc >= TimeoutLim) begin
                    ref_out_d  = '0;
                    meas_out_d = '0;
                    ref_cnt_d  = '0;
                    meas_cnt_d = '0;
                    state_d    = ARM;
                end else begin
                    ref_cnt_d = ref_inc;
                    if (meas_edge) begin
                        meas_cnt_d = meas_inc;
                    end
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= ARM;
            ref_cnt_q  <= '0;
            meas_cnt_q <= '0;
            ref_out_q  <= '0;
            meas_out_q <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            meas_cnt_q <= meas_cnt_d;
            ref_out_q  <= ref_out_d;
            meas_out_q <= meas_out_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign ref_out       = ref_out_q;
    assign meas_out      = meas_out_q;
    assign start_pos_ext = start_q;
    assign start_neg_ext = ~start_q;
    assign stop_pos_ext  = stop_q;
    assign stop_neg_ext  = ~stop_q;

endmodule

// File: tb/tb_frequency_meter.sv
// Scoreboard bench for frequency_meter with a shortened gate (1000 cycles)
// so each scenario runs a few gates.
module tb_frequency_meter;

    localparam int unsigned Gate    = 1000;
    localparam int unsigned Timeout = 4000;
    localparam int unsigned CntW    = 32;

    typedef struct {
        bit          ratio;  // range/ratio check instead of exact values
        int unsigned ref_lo;
        int unsigned ref_hi;
        int unsigned meas_v; // exact meas count, or clk_meas period for ratio
    } exp_t;

    logic            sys_rstn;
    logic            clk_ref;
    logic            clk_meas;
    logic [CntW-1:0] ref_out;
    logic [CntW-1:0] meas_out;
    logic            start_pos_ext, start_neg_ext, stop_pos_ext, stop_neg_ext;

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    time         first_stop_time = 0;
    int unsigned meas_period = 1000;
    bit          meas_run = 1'b0;

    frequency_meter #(
        .GATE_CYCLES    (Gate),
        .TIMEOUT_CYCLES (Timeout),
        .CNT_W          (CntW)
    ) dut (
        .sys_rstn      (sys_rstn),
        .clk_ref       (clk_ref),
        .clk_meas      (clk_meas),
        .ref_out       (ref_out),
        .meas_out      (meas_out),
        .start_pos_ext (start_pos_ext),
        .start_neg_ext (start_neg_ext),
        .stop_pos_ext  (stop_pos_ext),
        .stop_neg_ext  (stop_neg_ext)
    );

    initial begin
        clk_ref = 1'b0;
        forever #50 clk_ref = ~clk_ref;
    end

    // Rises immediately when meas_run is set; a stop takes effect after the
    // current period completes.
    initial begin
        clk_meas = 1'b0;
        forever begin
            if (!meas_run) begin
                clk_meas = 1'b0;
                wait (meas_run);
            end
            clk_meas = 1'b1;
            #(meas_period / 2);
            clk_meas = 1'b0;
            #(meas_period - meas_period / 2);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exact(input int unsigned n, input int unsigned r, input int unsigned m);
        for (int i = 0; i < n; i++) sb.push_back('{ratio: 1'b0, ref_lo: r, ref_hi: r, meas_v: m});
    endtask

    task automatic push_ratio(input int unsigned n, input int unsigned period);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{ratio: 1'b1, ref_lo: Gate, ref_hi: Gate + 10, meas_v: period});
        end
    endtask

    task automatic wait_drain(input int unsigned budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_ref);
            if (sb.size() == 0) break;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_in_reset();
        check("rst_ref_out", 64'(ref_out), 64'd0);
        check("rst_meas_out", 64'(meas_out), 64'd0);
        check("rst_start_pos", 64'(start_pos_ext), 64'd0);
        check("rst_start_neg", 64'(start_neg_ext), 64'd1);
        check("rst_stop_pos", 64'(stop_pos_ext), 64'd0);
        check("rst_stop_neg", 64'(stop_neg_ext), 64'd1);
    endtask

    task automatic restart(input int unsigned period);
        meas_run = 1'b0;
        #2100;
        @(negedge clk_ref);
        sys_rstn = 1'b0;
        #1;
        check_in_reset();
        #199;
        sys_rstn    = 1'b1;
        meas_period = period;
        meas_run    = 1'b1;
    endtask

    // Scoreboard consumer: every stop strobe must match the oldest expectation.
    always @(negedge clk_ref) begin
        if (sys_rstn && stop_pos_ext) begin
            if (first_stop_time == 0) first_stop_time = $time;
            check("stop_with_start", 64'(start_pos_ext), 64'd1);
            check("stop_neg", 64'(stop_neg_ext), 64'd0);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.ratio) begin
                    longint diff;
                    diff = longint'(meas_out) * longint'(mon_e.meas_v) - longint'(ref_out) * 100;
                    if (diff < 0) diff = -diff;
                    check("ratio_ref_in_range",
                          64'(ref_out >= mon_e.ref_lo && ref_out <= mon_e.ref_hi), 64'd1);
                    check("ratio_err_le_100ns", 64'(diff <= 100), 64'd1);
                end else begin
                    check("ref_out", 64'(ref_out), 64'(mon_e.ref_lo));
                    check("meas_out", 64'(meas_out), 64'(mon_e.meas_v));
                end
            end else begin
                check("stop_unexpected", 64'(stop_pos_ext), 64'd0);
            end
        end
    end

    initial begin
        time t_rel;
        time t_stop;
        bit  seen;

        sys_rstn = 1'b0;
        #20;
        check_in_reset();
        #80;
        sys_rstn = 1'b1;

        // Nominal 1 MHz, first rise at 525: start strobe after the 750 edge.
        #425;
        meas_period = 1000;
        meas_run    = 1'b1;
        push_exact(3, Gate, Gate / 10);
        #175;
        check("start_before", 64'(start_pos_ext), 64'd0);
        #100;
        check("start_pulse", 64'(start_pos_ext), 64'd1);
        check("start_neg_pulse", 64'(start_neg_ext), 64'd0);
        check("stop_not_at_open", 64'(stop_pos_ext), 64'd0);
        #100;
        check("start_after", 64'(start_pos_ext), 64'd0);
        check("start_neg_after", 64'(start_neg_ext), 64'd1);
        wait_drain(4000);
        check("first_stop_time", 64'(first_stop_time), 64'd100800);

        // 2.5 MHz input.
        restart(400);
        push_exact(3, Gate, Gate / 4);
        wait_drain(4000);

        // Non-integer ratio.
        restart(1030);
        push_ratio(3, 1030);
        wait_drain(4500);

        // Stuck input: gate must time out with zeroed outputs and no stop.
        meas_run = 1'b0;
        check("stuck_pre_nonzero", 64'(ref_out != 0), 64'd1);
        repeat (Timeout + 500) @(negedge clk_ref);
        check("stuck_ref_out", 64'(ref_out), 64'd0);
        check("stuck_meas_out", 64'(meas_out), 64'd0);
        meas_period = 1000;
        meas_run    = 1'b1;
        push_exact(2, Gate, Gate / 10);
        wait_drain(3500);

        // Reset in the middle of a gate.
        repeat (500) @(negedge clk_ref);
        sys_rstn = 1'b0;
        #1;
        check_in_reset();
        #199;
        sys_rstn = 1'b1;
        t_rel    = $time;
        push_exact(2, Gate, Gate / 10);
        seen   = 1'b0;
        t_stop = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_ref);
            if (stop_pos_ext) begin
                seen   = 1'b1;
                t_stop = $time;
                break;
            end
        end
        check("rst_mid_stop_seen", 64'(seen), 64'd1);
        check("rst_mid_gap_ok",
              64'((t_stop - t_rel) >= 100000 && (t_stop - t_rel) <= 101500), 64'd1);
        wait_drain(1500);

        meas_run = 1'b0;
        #2000;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
